// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, word geometry, wait counter, latched request.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W           = $clog2(MAX_WAIT_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic                  write;
    logic [31:0]           wdata;
    logic [WORD_BYTES-1:0] be;
  } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data port: valid/ready request channel, one-cycle response pulse and a stall hint.
interface dmem_responder_if #(
  parameter int ADDR_W = 32
);
  import dmem_pkg::*;

  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [31:0]           req_wdata;
  logic [WORD_BYTES-1:0] req_be;
  logic                  req_ready;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array with byte-lane writes; read data registered one edge after en.
// No backpressure: every enabled cycle performs exactly one read or write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: accepts one request in IDLE, responds WAIT_CYCLES+1 cycles later (errors after 1).
// Backpressure: req_ready only in IDLE; busy asks the core to freeze while an access is outstanding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t                state;
  cnt_t                  cnt;
  req_t                  req_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [31:0]           hold_q;

  logic                  accept;
  logic                  addr_err;
  logic [ADDR_W-1:0]     word_addr;
  logic                  commit_now;
  logic                  commit_wait;
  logic                  arr_en;
  logic                  arr_we;
  logic [WORD_BYTES-1:0] arr_be;
  logic [IDX_W-1:0]      arr_addr;
  logic [31:0]           arr_wdata;
  logic [31:0]           arr_rdata;
  logic [31:0]           rdata;

  assign word_addr = bus.req_addr >> 2;
  assign addr_err  = (bus.req_addr[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH_WORDS));
  assign accept    = (state == IDLE) && bus.req_valid;

  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = accept || (state == WAIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rdata;

  // With no wait states the access happens on the acceptance edge from the live inputs.
  assign commit_now  = ZERO_WAIT && accept && !addr_err;
  assign commit_wait = (state == WAIT) && (cnt == '0);
  assign arr_en      = !rst && (commit_now || commit_wait);
  assign arr_we      = commit_now ? bus.req_write             : req_q.write;
  assign arr_be      = commit_now ? bus.req_be                : req_q.be;
  assign arr_addr    = commit_now ? bus.req_addr[IDX_W+1:2]   : idx_q;
  assign arr_wdata   = commit_now ? bus.req_wdata             : req_q.wdata;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Array read data is live only in RESP; hold_q keeps the last response visible afterwards.
  always_comb begin
    rdata = hold_q;
    if (state == RESP && !resp_err_q) begin
      rdata = req_q.write ? 32'h0 : arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      hold_q       <= '0;
      req_q        <= '0;
      idx_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q <= '{write: bus.req_write, wdata: bus.req_wdata, be: bus.req_be};
            idx_q <= bus.req_addr[IDX_W+1:2];
            if (addr_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (ZERO_WAIT) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end
        RESP: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          hold_q       <= rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states and one with none, sharing the request stimulus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  bit          sel;
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(32)) if2 ();
  dmem_responder_if #(.ADDR_W(32)) if0 ();

  assign if2.req_valid = req_valid;
  assign if2.req_write = req_write;
  assign if2.req_addr  = req_addr;
  assign if2.req_wdata = req_wdata;
  assign if2.req_be    = req_be;
  assign if0.req_valid = req_valid;
  assign if0.req_write = req_write;
  assign if0.req_addr  = req_addr;
  assign if0.req_wdata = req_wdata;
  assign if0.req_be    = req_be;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) u_w2 (
    .clk (clk), .rst (rst), .bus (if2.slave));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) u_w0 (
    .clk (clk), .rst (rst), .bus (if0.slave));

  logic        ob_ready, ob_busy, ob_rvalid, ob_err;
  logic [31:0] ob_rdata;
  assign ob_ready  = sel ? if0.req_ready  : if2.req_ready;
  assign ob_busy   = sel ? if0.busy       : if2.busy;
  assign ob_rvalid = sel ? if0.resp_valid : if2.resp_valid;
  assign ob_err    = sel ? if0.resp_err   : if2.resp_err;
  assign ob_rdata  = sel ? if0.resp_rdata : if2.resp_rdata;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                              logic err, logic [31:0] rd, int lat);
    vec_t v;
    v.w = w; v.addr = a; v.wdata = d; v.be = be; v.err = err; v.rd = rd; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called just after a rising edge; returns just after a rising edge once the pulse has ended.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic exp_err, input logic [31:0] exp_rd, input int lat, input string tag);
    int          got = -1;
    logic        busy_ok = 1'b1;
    logic        gerr = 1'b0;
    logic [31:0] grd = '0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_ready"}, 32'(ob_ready), 32'd1);
      if (got >= 0) begin
        chk({tag, "_pulse"}, 32'(ob_rvalid), 32'd0);
        break;
      end
      if (ob_busy !== (c < lat)) busy_ok = 1'b0;
      if (ob_rvalid === 1'b1) begin
        got = c; gerr = ob_err; grd = ob_rdata;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        // Scramble inputs after acceptance; the latched copy must be used.
        req_valid = 1'b0; req_write = ~w; req_addr = a + 32'd4; req_wdata = ~d; req_be = ~be;
      end
    end
    chk({tag, "_busy"},  32'(busy_ok), 32'd1);
    chk({tag, "_lat"},   32'(got), 32'(lat));
    chk({tag, "_err"},   32'(gerr), 32'(exp_err));
    chk({tag, "_rdata"}, grd, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        saw_resp;
    int          acc;
    logic [2:0]  exp_t;
    sel = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid",  32'(if2.resp_valid), 32'd0);
    chk("rst_err",    32'(if2.resp_err),   32'd0);
    chk("rst_rdata",  if2.resp_rdata,      32'd0);
    chk("rst_ready",  32'(if2.req_ready),  32'd1);
    chk("rst_busy",   32'(if2.busy),       32'd0);
    chk("rst0_valid", 32'(if0.resp_valid), 32'd0);
    chk("rst0_rdata", if0.resp_rdata,      32'd0);
    @(posedge clk); #1;

    vt[0]  = mk(1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        3);
    vt[1]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 3);
    vt[2]  = mk(1'b1, 32'h10,  32'h0000AA00, 4'h2, 1'b0, 32'h0,        3);
    vt[3]  = mk(1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADAAEF, 3);
    vt[4]  = mk(1'b0, 32'h12,  32'h0,        4'hF, 1'b1, 32'hDEADAAEF, 1);
    vt[5]  = mk(1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADAAEF, 3);
    vt[6]  = mk(1'b0, 32'h400, 32'h0,        4'hF, 1'b1, 32'hDEADAAEF, 1);
    vt[7]  = mk(1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        3);
    vt[8]  = mk(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        3);
    vt[9]  = mk(1'b0, 32'h3FC, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 3);
    vt[10] = mk(1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADAAEF, 3);
    vt[11] = mk(1'b1, 32'h11,  32'h55555555, 4'hF, 1'b1, 32'hDEADAAEF, 1);
    vt[12] = mk(1'b0, 32'h10,  32'h0,        4'hF, 1'b0, 32'hDEADAAEF, 3);

    for (int i = 0; i < 13; i++) begin
      txn(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].err, vt[i].rd, vt[i].lat,
          $sformatf("v%0d", i));
    end

    // Reset during the first wait cycle drops the store without a response.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy_wait", 32'(if2.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_resp = 1'b0;
    @(negedge clk);
    chk("mid_ready_idle", 32'(if2.req_ready), 32'd1);
    chk("mid_rdata_rst",  if2.resp_rdata,     32'd0);
    for (int c = 0; c < 5; c++) begin
      if (if2.resp_valid !== 1'b0) saw_resp = 1'b1;
      @(negedge clk);
    end
    chk("mid_no_resp", 32'(saw_resp), 32'd0);
    @(posedge clk); #1;
    txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADAAEF, 3, "mid_ld");

    // Back-to-back loads with req_valid held high: one acceptance every four cycles.
    acc = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_t = {(c % 4 == 0), (c % 4 != 3), (c % 4 == 3)};
      chk($sformatf("b2b_c%0d", c), 32'({if2.req_ready, if2.busy, if2.resp_valid}), 32'(exp_t));
      if (if2.req_ready === 1'b1) acc++;
      @(posedge clk); #1;
      if (c % 4 == 0) req_addr = (req_addr == 32'h10) ? 32'h3FC : 32'h10;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    repeat (6) @(posedge clk);
    #1;

    // Zero wait states: response the cycle after acceptance.
    sel = 1'b1;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1, "w0_st");
    txn(1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 1, "w0_ld");
    txn(1'b0, 32'h12, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1, "w0_mis");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that serves the pipelined core's load/store requests over a valid/ready request channel and a one-cycle response pulse. It sits at the MEM-stage end of the core's data port and replaces the single-cycle data memory. It provides configurable wait states, per-byte write enables, and alignment/range error detection. A combinational busy output lets the core freeze its pipeline while an access is outstanding.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array (power of two)
WAIT_CYCLES, 2, wait-state cycles between acceptance and response (0..15)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core presents a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data
req_be  in  4  byte-lane enables for stores; bit i selects wdata[8i+7:8i]
req_ready  out  1  request accepted this cycle if req_valid is high
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load data; held between responses
resp_err  out  1  qualifies resp_valid; misaligned or out-of-range access
busy  out  1  core stall request

Behaviour:
- Reset: synchronous, active-high. Reset is one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, counter=0. Array contents are not reset.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE). Acceptance = req_valid && req_ready. On acceptance, write, addr, wdata and be are latched.
- busy = (state==IDLE && req_valid) || state==WAIT. busy is 0 in RESP, so the core advances in the cycle the data is present.
- Error check at acceptance: error if req_addr[1:0]!=0 or word index req_addr>>2 >= DEPTH_WORDS.
  - Error: IDLE->RESP directly. resp_err=1. No array access. resp_rdata unchanged.
- Valid request:
  - If WAIT_CYCLES==0: IDLE->RESP, with the array access on the acceptance edge.
  - Otherwise: IDLE->WAIT, counter loaded with WAIT_CYCLES-1. WAIT decrements each cycle. When counter==0, WAIT->RESP and the array access occurs on that edge.
- Latency: with acceptance in cycle 0, resp_valid is high in cycle WAIT_CYCLES+1 for exactly one cycle. An error responds in cycle 1.
- Store access: update only bytes whose be bit is set. be=4'b0000 is a legal no-op that still responds. resp_rdata on a store response = 0.
- Load access: full word into resp_rdata; be is ignored.
- RESP->IDLE unconditionally. The minimum request spacing is therefore WAIT_CYCLES+2 cycles, with a one-cycle bubble after RESP.
- Request inputs are ignored outside IDLE. Changes during WAIT have no effect, because the latched copy is used.
- Reset mid-operation: return to IDLE. A store not yet committed (still in WAIT) is dropped. No response is issued.
- Address bits above the index are used only for the range check; there is no wrap-around.

Decomposition:
- dmem_pkg holds:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - WORD_BYTES=4
  - the counter width derived from the maximum WAIT_CYCLES (4 bits)
- One sub-module, dmem_array: a synchronous single-port word array with 4 byte-lane write enables, a registered read, and DEPTH_WORDS as its parameter. The FSM, counter and error logic stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x10, be=4'b1111, accepted in cycle 0 -> busy=1 in cycles 0-2, resp_valid=1 and resp_err=0 in cycle 3 only.
  - Then load 0x10 -> resp_rdata=0xDEADBEEF.
- Store 0x0000AA00 to 0x10 with be=4'b0010 -> a subsequent load of 0x10 returns 0xDEADAAEF.
- Load from 0x12 (misaligned) -> resp_valid=1 and resp_err=1 in cycle 1; resp_rdata unchanged; a later load of 0x10 is unaffected.
- Load from 0x400 with DEPTH_WORDS=256 -> resp_err=1 in cycle 1.
- Store 0x12345678 to 0x10, with rst asserted in the first WAIT cycle -> no resp_valid; state IDLE next cycle; a subsequent load of 0x10 returns the old value 0xDEADAAEF.
- req_valid held high with alternating loads -> acceptances every 4 cycles; req_ready pattern 1,0,0,0; busy pattern 1,1,1,0.
- Rerun the first store/load pair with WAIT_CYCLES=0 -> resp_valid in cycle 1.
